// File: rtl/pipeline_control_unit_pkg.sv
// Shared encodings for the pipeline control slice: opcodes, ALU ops,
// result-mux and forward selects, plus the staged control bundles.
package pipeline_control_unit_pkg;

   typedef enum logic [6:0] {
      OP_LOAD  = 7'b0000011,
      OP_STORE = 7'b0100011,
      OP_RTYPE = 7'b0110011,
      OP_IALU  = 7'b0010011,
      OP_BEQ   = 7'b1100011,
      OP_JAL   = 7'b1101111
   } opcode_e;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_op_e;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_e;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   typedef struct packed {
      logic       reg_we;
      logic       mem_we;
      logic       src_b;
      logic [1:0] result_src;
      logic [2:0] alu_op;
   } ctrl_t;

   typedef struct packed {
      logic       reg_we;
      logic       mem_we;
      logic [1:0] result_src;
   } mem_ctrl_t;

   typedef struct packed {
      logic       reg_we;
      logic [1:0] result_src;
   } wb_ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

   // Unlisted funct3 values fall back to add.
   function automatic logic [2:0] alu_from_funct3(input logic [2:0] funct3,
                                                  input logic       sub_sel);
      logic [2:0] op;
      case (funct3)
         3'b000:  op = sub_sel ? ALU_SUB : ALU_ADD;
         3'b010:  op = ALU_SLT;
         3'b110:  op = ALU_OR;
         3'b111:  op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/pipeline_control_unit_main_decoder.sv
// Combinational main decoder: opcode/funct fields to execute-stage control.
// Unknown opcodes yield all-zero control and raise illegal_o.
module main_decoder
   import pipeline_control_unit_pkg::*;
(
   input  logic [6:0] opcode_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   output logic       reg_we_o,
   output logic       mem_we_o,
   output logic       src_b_o,
   output logic [1:0] result_src_o,
   output logic [2:0] alu_op_o,
   output logic       illegal_o
);

   always_comb begin
      reg_we_o     = 1'b0;
      mem_we_o     = 1'b0;
      src_b_o      = 1'b0;
      result_src_o = RES_ALU;
      alu_op_o     = ALU_ADD;
      illegal_o    = 1'b0;
      case (opcode_i)
         OP_LOAD: begin
            reg_we_o     = 1'b1;
            src_b_o      = 1'b1;
            result_src_o = RES_MEM;
         end
         OP_STORE: begin
            mem_we_o = 1'b1;
            src_b_o  = 1'b1;
         end
         OP_RTYPE: begin
            reg_we_o = 1'b1;
            alu_op_o = alu_from_funct3(funct3_i, funct7b5_i);
         end
         OP_IALU: begin
            reg_we_o = 1'b1;
            src_b_o  = 1'b1;
            alu_op_o = alu_from_funct3(funct3_i, 1'b0);
         end
         OP_BEQ: begin
            alu_op_o = ALU_SUB;
         end
         OP_JAL: begin
            reg_we_o     = 1'b1;
            result_src_o = RES_PC4;
         end
         default: begin
            illegal_o = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/pipeline_control_unit.sv
// Pipeline control: decode, D->E->M->W control staging, load-use/RAW stall,
// branch flush and operand forwarding (PIPELINE_CONTROL_UNIT_FORWARDING_EN).
module pipeline_control_unit
   import pipeline_control_unit_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned ALU_OP_W   = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [6:0]            opcode_D,
   input  logic [2:0]            funct3_D,
   input  logic                  funct7b5_D,
   input  logic [REG_ADDR_W-1:0] rs1_D,
   input  logic [REG_ADDR_W-1:0] rs2_D,
   input  logic [REG_ADDR_W-1:0] rd_D,
   input  logic                  branch_taken_E,
   output logic                  stall_F,
   output logic                  stall_D,
   output logic                  flush_D,
   output logic                  reg_WE_E,
   output logic                  reg_WE_M,
   output logic                  reg_WE_W,
   output logic                  mem_WE_E,
   output logic                  mem_WE_M,
   output logic                  srcB_E,
   output logic [1:0]            result_src_E,
   output logic [1:0]            result_src_M,
   output logic [1:0]            result_src_W,
   output logic [ALU_OP_W-1:0]   ALU_op_E,
   output logic [REG_ADDR_W-1:0] rd_W,
   output logic [1:0]            fwd_A_E,
   output logic [1:0]            fwd_B_E,
   output logic                  illegal_D
);

   logic       dec_reg_we, dec_mem_we, dec_src_b;
   logic [1:0] dec_result_src;
   logic [2:0] dec_alu_op;
   ctrl_t      dec_ctrl;

   ctrl_t                 ctrl_e_q, ctrl_e_d;
   mem_ctrl_t             ctrl_m_q, ctrl_m_d;
   wb_ctrl_t              ctrl_w_q, ctrl_w_d;
   logic [REG_ADDR_W-1:0] rd_e_q, rd_e_d, rd_m_q, rd_w_q;
   logic                  hit_e, hazard, bubble_e;

   main_decoder u_main_decoder (
      .opcode_i     (opcode_D),
      .funct3_i     (funct3_D),
      .funct7b5_i   (funct7b5_D),
      .reg_we_o     (dec_reg_we),
      .mem_we_o     (dec_mem_we),
      .src_b_o      (dec_src_b),
      .result_src_o (dec_result_src),
      .alu_op_o     (dec_alu_op),
      .illegal_o    (illegal_D)
   );

   assign dec_ctrl = '{reg_we: dec_reg_we, mem_we: dec_mem_we, src_b: dec_src_b,
                       result_src: dec_result_src, alu_op: dec_alu_op};

   // Hazards look only at registered E/M contents, so reset clears any stall.
`ifdef PIPELINE_CONTROL_UNIT_FORWARDING_EN
   always_comb begin
      hit_e  = (rd_e_q != '0) && ((rd_e_q == rs1_D) || (rd_e_q == rs2_D));
      hazard = hit_e && (ctrl_e_q.result_src == RES_MEM);
   end
`else
   logic hit_m;
   always_comb begin
      hit_e  = (rd_e_q != '0) && ((rd_e_q == rs1_D) || (rd_e_q == rs2_D));
      hit_m  = (rd_m_q != '0) && ((rd_m_q == rs1_D) || (rd_m_q == rs2_D));
      hazard = (hit_e && ctrl_e_q.reg_we) || (hit_m && ctrl_m_q.reg_we);
   end
`endif

   // A taken branch wins over a stall: decode is killed, not held.
   assign stall_F  = hazard & ~branch_taken_E;
   assign stall_D  = stall_F;
   assign flush_D  = branch_taken_E;
   assign bubble_e = stall_F | branch_taken_E;

   always_comb begin
      ctrl_e_d = dec_ctrl;
      rd_e_d   = illegal_D ? '0 : rd_D;
      if (bubble_e) begin
         ctrl_e_d = CTRL_BUBBLE;
         rd_e_d   = '0;
      end
      ctrl_m_d = '{reg_we: ctrl_e_q.reg_we, mem_we: ctrl_e_q.mem_we,
                   result_src: ctrl_e_q.result_src};
      ctrl_w_d = '{reg_we: ctrl_m_q.reg_we, result_src: ctrl_m_q.result_src};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_e_q <= CTRL_BUBBLE;
         ctrl_m_q <= '0;
         ctrl_w_q <= '0;
         rd_e_q   <= '0;
         rd_m_q   <= '0;
         rd_w_q   <= '0;
      end else begin
         ctrl_e_q <= ctrl_e_d;
         ctrl_m_q <= ctrl_m_d;
         ctrl_w_q <= ctrl_w_d;
         rd_e_q   <= rd_e_d;
         rd_m_q   <= rd_e_q;
         rd_w_q   <= rd_m_q;
      end
   end

`ifdef PIPELINE_CONTROL_UNIT_FORWARDING_EN
   logic [REG_ADDR_W-1:0] rs1_e_q, rs1_e_d, rs2_e_q, rs2_e_d;
   logic [1:0]            fwd_a, fwd_b;

   assign rs1_e_d = bubble_e ? '0 : rs1_D;
   assign rs2_e_d = bubble_e ? '0 : rs2_D;

   always_ff @(posedge clk) begin
      if (rst) begin
         rs1_e_q <= '0;
         rs2_e_q <= '0;
      end else begin
         rs1_e_q <= rs1_e_d;
         rs2_e_q <= rs2_e_d;
      end
   end

   always_comb begin
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
      if (ctrl_m_q.reg_we && (rd_m_q != '0) && (rd_m_q == rs1_e_q))
         fwd_a = FWD_MEM;
      else if (ctrl_w_q.reg_we && (rd_w_q != '0) && (rd_w_q == rs1_e_q))
         fwd_a = FWD_WB;
      if (ctrl_m_q.reg_we && (rd_m_q != '0) && (rd_m_q == rs2_e_q))
         fwd_b = FWD_MEM;
      else if (ctrl_w_q.reg_we && (rd_w_q != '0) && (rd_w_q == rs2_e_q))
         fwd_b = FWD_WB;
   end

   assign fwd_A_E = fwd_a;
   assign fwd_B_E = fwd_b;
`else
   assign fwd_A_E = '0;
   assign fwd_B_E = '0;
`endif

   assign reg_WE_E     = ctrl_e_q.reg_we;
   assign mem_WE_E     = ctrl_e_q.mem_we;
   assign srcB_E       = ctrl_e_q.src_b;
   assign result_src_E = ctrl_e_q.result_src;
   assign ALU_op_E     = ALU_OP_W'(ctrl_e_q.alu_op);
   assign reg_WE_M     = ctrl_m_q.reg_we;
   assign mem_WE_M     = ctrl_m_q.mem_we;
   assign result_src_M = ctrl_m_q.result_src;
   assign reg_WE_W     = ctrl_w_q.reg_we;
   assign result_src_W = ctrl_w_q.result_src;
   assign rd_W         = rd_w_q;

endmodule

// File: doc/pipeline_control_unit.md
PIPELINE_CONTROL_UNIT -- requirements
Module: pipeline_control_unit

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-address width.
REQ-002 SHALL have parameter ALU_OP_W, default 3, ALU-operation code width (minimum 3).
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 opcode_D  input  7  decode-stage instruction opcode.
REQ-007 funct3_D  input  3  / funct7b5_D  input  1  decode-stage function fields.
REQ-008 rs1_D, rs2_D, rd_D  input  REG_ADDR_W  decode-stage register addresses.
REQ-009 branch_taken_E  input  1  execute-stage resolved branch/jump redirect.
REQ-010 stall_F, stall_D, flush_D  output  1  fetch/decode hold and decode kill.
REQ-011 reg_WE_E/M/W, mem_WE_E/M, srcB_E  output  1  staged control bits.
REQ-012 result_src_E/M/W  output  2  staged result-mux select: 00 ALU, 01 memory, 10 PC+4.
REQ-013 ALU_op_E  output  ALU_OP_W  execute-stage ALU operation.
REQ-014 rd_W  output  REG_ADDR_W  writeback destination.
REQ-015 fwd_A_E, fwd_B_E  output  2  operand forward select: 00 register file, 01 writeback, 10 memory.
REQ-016 illegal_D  output  1  unrecognised opcode in decode.

Function
REQ-017 Decode (combinational): 0000011 load; 0100011 store; 0110011 R-type; 0010011 I-ALU; 1100011 beq; 1101111 jal; any other opcode produces all-zero control and illegal_D=1.
REQ-018 ALU_op: 000 add, 001 sub, 010 and, 011 or, 101 slt; load/store/jal use add, beq uses sub, R/I use funct3 (funct7b5 selects sub only for R-type), upper bits zero-extended when ALU_OP_W>3.
REQ-019 Decoded control, rd, rs1 and rs2 SHALL advance D->E->M->W one stage per cycle through registered pipeline stages; latency from decode to each stage output is exactly 1, 2 and 3 cycles.
REQ-020 Load-use hazard: when the E-stage instruction is a load with rd_E≠0 and rd_E equals rs1_D or rs2_D, stall_F=stall_D=1 and a bubble (all-zero control) SHALL be inserted into E for one cycle.
REQ-021 branch_taken_E=1 SHALL assert flush_D combinationally and load a bubble into E on the next edge; redirect overrides stall when both occur in the same cycle.
REQ-022 Forwarding: fwd_x_E=10 when reg_WE_M, rd_M≠0 and rd_M equals rs_x_E; else 01 under the same rule for the W stage; else 00; M has priority over W.
REQ-023 Register address 0 SHALL never trigger a hazard or forward.
REQ-024 A bubble SHALL carry rd=0 and all write enables low.

Reset
REQ-025 On rst, every E/M/W pipeline register SHALL hold the bubble value; all staged outputs, fwd selects and rd_W read 0 from the first edge with rst high.
REQ-026 rst asserted mid-stall or mid-flush SHALL clear stall/flush state; stall_F/stall_D depend only on current pipeline contents.

Configuration
REQ-027 Macro PIPELINE_CONTROL_UNIT_FORWARDING_EN: when defined, REQ-022 applies; when undefined, fwd_A_E/fwd_B_E SHALL be constant 00 and any RAW dependency of rs1_D/rs2_D on a valid rd in E or M SHALL stall as in REQ-020 until resolved.

Structure
REQ-028 Opcode constants, ALU_op encodings, result_src encodings and forward-select encodings SHALL reside in a shared package, e.g. riscv_ctrl_pkg.
REQ-029 The combinational decoder SHALL be a sub-module named main_decoder; hazard, forwarding and pipeline registers reside in the top.

Verification
REQ-030 rst 2 cycles -> all staged outputs 0, stall_F=0, flush_D=0.
REQ-031 add x3,x1,x2 in decode -> reg_WE_E=1, ALU_op_E=000 after 1 cycle, reg_WE_W=1, rd_W=3 after 3 cycles.
REQ-032 lw x5 followed by add x6,x5,x1 -> stall_F=stall_D=1 for exactly one cycle, bubble in E, then fwd_A_E=01.
REQ-033 add x7 followed by sub x8,x7,x7 (forwarding enabled) -> fwd_A_E=fwd_B_E=10, no stall.
REQ-034 branch_taken_E=1 during a load-use stall -> flush_D=1, stall deasserted, E holds bubble next cycle.
REQ-035 opcode 1111111 -> illegal_D=1, and a bubble reaches W 3 cycles later.
